irq_encoder_8x3: RTL and testbench
==================================

# irq_encoder_8x3

- Sequential 8-to-3 priority encoder that collects eight request lines into a pending register and presents one request at a time as a 3-bit code with a valid/ack handshake.
- Fixed priority: bit 7 highest, bit 0 lowest.
- Sits in the processor's interrupt/exception front end. The fetch/control stage consumes CODE; the register-file/CSR path holds the mask.

## Interface
Parameters:
- none (width fixed at 8 requests / 3-bit code)

Ports:
- CLK  input  1  single clock; all state updates on rising edge
- RST_N  input  1  reset, synchronous, active-low
- EN  input  1  grant enable; low blocks new grants, pending still accumulates
- REQ  input  8  request lines, one per source
- MASK_IN  input  8  new mask value (1 = source enabled)
- MASK_WE  input  1  load MASK_IN into mask register
- ACK  input  1  consumer accepts current CODE
- CODE  output  3  index of granted source
- VALID  output  1  CODE is valid and held
- PEND  output  8  raw pending register (unmasked)

## Operation
- Reset (RST_N low at a rising edge):
  - PEND = 8'h00, mask = 8'hFF, CODE = 3'd0, VALID = 0, state IDLE.
- Pending set:
  - Each cycle, pending[i] is set when source i requests (level or edge per Configuration).
  - Masked sources still set pending; the mask gates only grant selection.
- Pending clear:
  - The bit pending[CODE] clears when VALID && ACK at an edge.
  - Same bit set and cleared in the same cycle: set wins.
- Mask register:
  - MASK_WE loads MASK_IN at the edge.
  - A new mask affects selection starting the following cycle.
- State machine, two states:
  - IDLE: if EN && |(pending & mask), on the next edge load CODE = index of highest set bit of (pending & mask), set VALID = 1, go to HOLD. Otherwise CODE keeps its last value and VALID = 0.
  - HOLD: CODE and VALID are frozen. No pre-emption by higher-priority arrivals, mask writes, or EN deassertion. On ACK: VALID = 0, clear pending[CODE], go to IDLE.
- ACK with VALID = 0 is ignored.
- CODE is registered. No combinational path from REQ, MASK_IN or ACK to any output.

## Timing
- REQ high sampled at edge k → PEND bit set after edge k → VALID = 1 after edge k+1 (2-cycle latency, IDLE with EN high).
- ACK sampled high at edge m in HOLD → VALID = 0 and PEND bit cleared after edge m.
- Earliest next VALID is after edge m+1, so there is a mandatory one-cycle bubble between grants.
- Maximum sustained throughput is one grant per 2 cycles (ACK tied high).
- Reset mid-HOLD drops VALID and discards all pending at that edge. No partial completion.
- EN low in IDLE: no grant is issued; grant resumes one edge after EN returns high.
- All pending masked: the block stays in IDLE with VALID = 0 while PEND remains nonzero.

## Configuration
- Macro: IRQ_ENC_EDGE_DETECT_EN.
- Defined:
  - A registered copy of REQ (cleared to 0 on reset) is kept.
  - pending[i] sets only on a 0→1 transition of REQ[i].
  - A held-high request is granted once per rising edge.
  - The edge detection adds no extra latency beyond the 2 cycles above; the edge is detected combinationally against the previous-REQ register.
- Undefined:
  - Level-sensitive. pending[i] sets on every cycle REQ[i] is high.
  - A request held through ACK re-sets immediately (set wins) and is re-granted after the bubble.

## Test plan
- Reset, then REQ = 8'b0001_0100 for one cycle, ACK held low → VALID = 1 two cycles later, CODE = 3'd4, PEND = 8'h14. Hold 5 cycles: CODE stays 4.
- Continuing in HOLD, raise REQ[7] → CODE stays 4. ACK one cycle → VALID drops; next grant CODE = 7, then after ACK CODE = 2, then IDLE with PEND = 0.
- MASK_WE with MASK_IN = 8'h7F, then REQ = 8'h80 → PEND = 8'h80, VALID stays 0. Write MASK_IN = 8'hFF → CODE = 7 two cycles after the write.
- EN = 0 with REQ[1] pulsed → PEND = 8'h02, VALID = 0. Raise EN → VALID = 1, CODE = 1 on the next edge.
- REQ[3] held high, ACK tied high:
  - Level mode: VALID toggles 1,0,1,0 with CODE = 3 continuously.
  - With IRQ_ENC_EDGE_DETECT_EN: exactly one grant, then PEND = 0.
- RST_N low during HOLD (CODE = 5) → after that edge VALID = 0, CODE = 0, PEND = 0, mask = 8'hFF.

Source files
------------

// File: rtl/irq_encoder_8x3.sv
// irq_encoder_8x3: sequential 8-to-3 priority interrupt encoder with valid/ack handshake; IRQ_ENC_EDGE_DETECT_EN selects edge-triggered request capture
module irq_encoder_8x3 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] REQ,
  input  logic [7:0] MASK_IN,
  input  logic       MASK_WE,
  input  logic       ACK,
  output logic [2:0] CODE,
  output logic       VALID,
  output logic [7:0] PEND
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t     state;
  logic [7:0] mask;
  logic [7:0] req_set;
  logic [7:0] clr;
  logic [7:0] elig;
  logic [2:0] top;
`ifdef IRQ_ENC_EDGE_DETECT_EN
  logic [7:0] req_q;
  // previous REQ sample so a held line raises pending only on its rising edge
  always_ff @(posedge CLK)
    req_q <= !RST_N ? '0 : REQ;
  assign req_set = REQ & ~req_q;
`else
  assign req_set = REQ;
`endif
  assign elig = PEND & mask;
  assign clr  = (state == HOLD && ACK) ? 8'd1 << CODE : '0;
  // highest eligible index wins; later iterations overwrite lower ones
  always_comb begin
    top = '0;
    for (int i = 0; i < 8; i++)
      if (elig[i]) top = 3'(i);
  end
  // pending accumulates regardless of mask; a same-cycle set beats the ack clear
  always_ff @(posedge CLK)
    PEND <= !RST_N ? '0 : (PEND & ~clr) | req_set;
  // mask takes effect on selection the cycle after it is written
  always_ff @(posedge CLK)
    mask <= !RST_N ? 8'hFF : MASK_WE ? MASK_IN : mask;
  // grant FSM: latch a code in IDLE, freeze it in HOLD until acknowledged
  always_ff @(posedge CLK)
    if (!RST_N) begin
      state <= IDLE;
      CODE  <= '0;
      VALID <= 1'b0;
    end else if (state == IDLE) begin
      if (EN && |elig) begin
        CODE  <= top;
        VALID <= 1'b1;
        state <= HOLD;
      end
    end else if (ACK) begin
      VALID <= 1'b0;
      state <= IDLE;
    end
endmodule

// File: tb/tb_irq_encoder_8x3.sv
// tb_irq_encoder_8x3: directed plus randomized checks of irq_encoder_8x3 against a behavioural model
module tb_irq_encoder_8x3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] mask_in = 8'hFF;
  logic       mask_we = 1'b0;
  logic       ack = 1'b0;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  int checks = 0;
  int errors = 0;
  bit     m_pend[8];
  bit     m_mask[8];
  bit     m_prev[8];
  bit     m_valid;
  int     m_code;
  irq_encoder_8x3 dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .REQ(req), .MASK_IN(mask_in),
    .MASK_WE(mask_we), .ACK(ack), .CODE(code), .VALID(valid), .PEND(pend)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [7:0] m_pend_bits();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = m_pend[i];
    return r;
  endfunction
  task automatic model_edge();
    bit nxt[8];
    int best = -1;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
      end
      m_valid = 0;
      m_code  = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
`ifdef IRQ_ENC_EDGE_DETECT_EN
      nxt[i] = m_pend[i] || (req[i] && !m_prev[i]);
`else
      nxt[i] = m_pend[i] || req[i];
`endif
    end
    if (m_valid) begin
      if (ack) begin
        m_valid = 0;
        if (!(req[m_code]
`ifdef IRQ_ENC_EDGE_DETECT_EN
              && !m_prev[m_code]
`endif
            )) nxt[m_code] = 0;
      end
    end else if (en) begin
      for (int i = 7; i >= 0; i--)
        if (best < 0 && m_pend[i] && m_mask[i]) best = i;
      if (best >= 0) begin
        m_valid = 1;
        m_code  = best;
      end
    end
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = nxt[i];
      m_prev[i] = req[i];
      if (mask_we) m_mask[i] = mask_in[i];
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("valid", {7'd0, valid}, {7'd0, m_valid});
    check("code", {5'd0, code}, 8'(m_code));
    check("pend", pend, m_pend_bits());
  endtask
  initial begin
    rst_n = 0;
    step();
    check("rst_pend", pend, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_code", {5'd0, code}, 8'd0);
    rst_n = 1;
    req = 8'h14; step();
    req = 8'h00; step();
    check("first_grant", {4'd0, valid, code}, 8'h0C);
    check("first_pend", pend, 8'h14);
    repeat (5) step();
    check("hold_code", {5'd0, code}, 8'd4);
    req = 8'h80; step();
    req = 8'h00;
    check("no_preempt", {5'd0, code}, 8'd4);
    ack = 1; step();
    check("ack_drop", {7'd0, valid}, 8'd0);
    ack = 0; step();
    check("grant7", {4'd0, valid, code}, 8'h0F);
    ack = 1; step();
    ack = 0; step();
    check("grant2", {4'd0, valid, code}, 8'h0A);
    ack = 1; step();
    ack = 0; step();
    check("drained", pend, 8'h00);
    mask_in = 8'h7F; mask_we = 1; step();
    mask_we = 0; req = 8'h80; step();
    req = 8'h00; step(); step();
    check("masked_pend", pend, 8'h80);
    check("masked_valid", {7'd0, valid}, 8'd0);
    mask_in = 8'hFF; mask_we = 1; step();
    mask_we = 0; step();
    check("unmask_grant", {4'd0, valid, code}, 8'h0F);
    ack = 1; step();
    ack = 0; en = 0; req = 8'h02; step();
    req = 8'h00; step(); step();
    check("en_low_pend", pend, 8'h02);
    check("en_low_valid", {7'd0, valid}, 8'd0);
    en = 1; step();
    check("en_resume", {4'd0, valid, code}, 8'h09);
    ack = 1; step();
    req = 8'h08; step(); step();
    check("held_first", {4'd0, valid, code}, 8'h0B);
    step();
`ifdef IRQ_ENC_EDGE_DETECT_EN
    check("held_once", {7'd0, valid}, 8'd0);
    check("held_pend", pend, 8'h00);
    step();
    check("held_no_regrant", {7'd0, valid}, 8'd0);
`else
    check("held_bubble", {7'd0, valid}, 8'd0);
    check("held_reset", pend, 8'h08);
    step();
    check("held_regrant", {4'd0, valid, code}, 8'h0B);
`endif
    req = 8'h00; repeat (3) step();
    ack = 0; req = 8'h20; step();
    req = 8'h00; step();
    check("pre_rst_code", {4'd0, valid, code}, 8'h0D);
    rst_n = 0; step();
    check("mid_rst", {4'd0, valid, code}, 8'h00);
    check("mid_rst_pend", pend, 8'h00);
    rst_n = 1; req = 8'h80; step();
    req = 8'h00; step();
    check("mask_reset", {4'd0, valid, code}, 8'h0F);
    for (int n = 0; n < 600; n++) begin
      req     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ack     = $urandom_range(0, 2) != 0;
      en      = $urandom_range(0, 5) != 0;
      mask_we = $urandom_range(0, 15) == 0;
      mask_in = 8'($urandom);
      rst_n   = $urandom_range(0, 99) != 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
